// File: rtl/mod_addsub_ctrl.sv
// Purpose : (A +/- B) mod M over 384 bits using two passes through a shared 4-cycle pipelined adder.
// Latency : done pulses 11 cycles after start is accepted, fixed for add/sub and all operand values.
// Backpressure: none; start is honoured only in IDLE and dropped otherwise (no queueing), busy flags the window.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, subtract          one-cycle request and op select (0: add, 1: sub), sampled in IDLE
//   in_a, in_b, in_m         operands and modulus, latched with start
//   busy, done, result       status, one-cycle completion pulse, registered result
//   add_start, add_cin,
//   add_a, add_b             request side of the shared adder (adder samples only on add_start)
//   add_c, add_done          adder sum (bit 384 = carry-out) and completion pulse
module mod_addsub_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         subtract,
    input  logic [383:0] in_a,
    input  logic [383:0] in_b,
    input  logic [383:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [383:0] result,
    output logic         add_start,
    output logic         add_cin,
    output logic [383:0] add_a,
    output logic [383:0] add_b,
    input  logic [384:0] add_c,
    input  logic         add_done
);

    localparam int N = 384;

    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        IDLE  = 3'd1,
        LOAD1 = 3'd2,
        WAIT1 = 3'd3,
        LOAD2 = 3'd4,
        WAIT2 = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     flush_cnt_q;

    // Operation context kept across both passes.
    logic           sub_q;
    logic [N-1:0]   m_q;
    logic [N-1:0]   s1_q;
    logic           k1_q;

    // Single-cycle events decoded from the FSM.
    logic           accept;
    logic           pass1_done;
    logic           pass2_done;

    // Second-pass sum and the reduction choice.
    logic [N-1:0]   s2;
    logic           k2;
    logic [N-1:0]   result_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FLUSH;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 2'd1 : 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Next state and event decode. add_done is only meaningful in the
    // two WAIT states; elsewhere it may be a leftover pass from before a
    // reset, which the FLUSH window is long enough to absorb.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        pass1_done = 1'b0;
        pass2_done = 1'b0;
        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = LOAD1;
                end
            end
            LOAD1: state_d = WAIT1;
            WAIT1: begin
                if (add_done) begin
                    pass1_done = 1'b1;
                    state_d    = LOAD2;
                end
            end
            LOAD2: state_d = WAIT2;
            WAIT2: begin
                if (add_done) begin
                    pass2_done = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = FLUSH;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // ------------------------------------------------------------------
    // Reduction select.
    // Add: pass 2 computed S1 - M. Either carry means A+B >= M, so take S2.
    // Sub: pass 1 computed A - B; a clear carry (k1=0) is a borrow, so the
    //      corrected S1 + M from pass 2 is the answer.
    // ------------------------------------------------------------------
    assign s2 = add_c[N-1:0];
    assign k2 = add_c[N];

    always_comb begin
        result_d = s1_q;
        if (sub_q) begin
            result_d = k1_q ? s1_q : s2;
        end else begin
            result_d = (k1_q | k2) ? s2 : s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath. The adder operand registers are loaded on the edge that
    // enters LOAD1/LOAD2 so add_start and its operands appear together in
    // the LOAD cycle. A and B are latched straight into add_a/add_b since
    // they are only needed by the first pass; the first-pass sum goes to
    // add_a directly from add_c for the same reason. Operands then hold,
    // as the adder samples them only on add_start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            add_start <= 1'b0;
            add_cin   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            result    <= '0;
            sub_q     <= 1'b0;
            m_q       <= '0;
            s1_q      <= '0;
            k1_q      <= 1'b0;
        end else begin
            add_start <= accept | pass1_done;

            if (accept) begin
                sub_q   <= subtract;
                m_q     <= in_m;
                add_a   <= in_a;
                add_b   <= subtract ? ~in_b : in_b;
                add_cin <= subtract;
            end

            if (pass1_done) begin
                s1_q    <= add_c[N-1:0];
                k1_q    <= add_c[N];
                add_a   <= add_c[N-1:0];
                // Add: S1 + ~M + 1 = S1 - M.  Sub: S1 + M.
                add_b   <= sub_q ? m_q : ~m_q;
                add_cin <= ~sub_q;
            end

            if (pass2_done) begin
                result <= result_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    a_start_in_load: assert property (@(posedge clk) disable iff (rst)
        add_start |-> (state_q == LOAD1 || state_q == LOAD2));

    a_done_is_busy: assert property (@(posedge clk) disable iff (rst)
        done |-> busy);

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Purpose : self-checking bench for mod_addsub_ctrl with a 4-cycle adder model and a modular-arithmetic reference.
// Latency : each operation is expected to complete with done exactly 11 cycles after start.
// Backpressure: exercises ignored starts while busy and a reset in the middle of an operation.
module tb_mod_addsub_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         subtract;
    logic [383:0] in_a;
    logic [383:0] in_b;
    logic [383:0] in_m;
    logic         busy;
    logic         done;
    logic [383:0] result;
    logic         add_start;
    logic         add_cin;
    logic [383:0] add_a;
    logic [383:0] add_b;
    logic [384:0] add_c;
    logic         add_done;

    int checks = 0;
    int errors = 0;

    mod_addsub_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .subtract  (subtract),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_m      (in_m),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .add_start (add_start),
        .add_cin   (add_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_done  (add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder model: start in cycle t -> done and sum in cycle t+4.
    // It has no reset, so a pass in flight survives a controller reset.
    logic [3:0]   pv = 4'b0;
    logic [384:0] pc [4];

    always @(posedge clk) begin
        pv[0] <= add_start;
        pc[0] <= {1'b0, add_a} + {1'b0, add_b} + {384'b0, add_cin};
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pc[i] <= pc[i-1];
        end
    end

    assign add_done = pv[3];
    assign add_c    = pv[3] ? pc[3] : {385{1'b1}};

    task automatic chk(input string tag, input logic [384:0] act, input logic [384:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [383:0] rnd384();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Reference: true modular add/sub, valid for A, B < M.
    function automatic logic [383:0] ref_model(input logic sub, input logic [383:0] a,
                                               input logic [383:0] b, input logic [383:0] m);
        logic [385:0] t;
        if (!sub) begin
            t = {2'b0, a} + {2'b0, b};
            if (t >= {2'b0, m}) t = t - {2'b0, m};
        end else if (a >= b) begin
            t = {2'b0, a} - {2'b0, b};
        end else begin
            t = {2'b0, a} + {2'b0, m} - {2'b0, b};
        end
        return t[383:0];
    endfunction

    // Called at a negedge with the DUT in IDLE (cycle 0). Returns at the
    // negedge of cycle 12. ign1/ign2 are cycles in which a stray start is driven.
    task automatic run_op(input string tag, input logic sub, input logic [383:0] a,
                          input logic [383:0] b, input logic [383:0] m,
                          input logic [383:0] exp, input int ign1, input int ign2);
        int dcnt;
        int dcyc;
        chk({tag, ".idle"}, busy, 0);
        start    = 1'b1;
        subtract = sub;
        in_a     = a;
        in_b     = b;
        in_m     = m;
        dcnt     = 0;
        dcyc     = -1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = (c == ign1) || (c == ign2);
            if (start) begin
                subtract = ~sub;
                in_a     = rnd384();
                in_b     = rnd384();
                in_m     = rnd384() | 384'd1;
            end
            if (c == 1) chk({tag, ".busy1"}, busy, 1);
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
        end
        chk({tag, ".done_cnt"}, dcnt, 1);
        chk({tag, ".done_cyc"}, dcyc, 11);
        chk({tag, ".result"}, result, exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [383:0] ones;
        logic [383:0] ra, rb, rm;
        logic         rs;
        int           dcnt;

        rst      = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_m     = '0;
        ones     = '1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy",      busy, 1);
        chk("rst.done",      done, 0);
        chk("rst.result",    result, 0);
        chk("rst.add_start", add_start, 0);
        chk("rst.add_cin",   add_cin, 0);
        chk("rst.add_a",     add_a, 0);
        chk("rst.add_b",     add_b, 0);
        rst = 1'b0;                      // now in r+1
        repeat (3) @(negedge clk);       // r+4
        chk("flush.busy_r4", busy, 1);
        @(negedge clk);                  // r+5
        chk("flush.idle_r5", busy, 0);

        // Directed cases
        run_op("add_noreduce", 1'b0, 384'd10, 384'd20, 384'd97, 384'd30, -1, -1);
        run_op("add_reduce",   1'b0, 384'd50, 384'd60, 384'd97, 384'd13, -1, -1);
        run_op("sub_noborrow", 1'b1, 384'd20, 384'd10, 384'd97, 384'd10, -1, -1);
        run_op("sub_borrow",   1'b1, 384'd10, 384'd20, 384'd97, 384'd87, -1, -1);
        run_op("carry_out",    1'b0, ones - 384'd1, ones - 384'd1, ones, ones - 384'd2, -1, -1);

        // Starts while busy are dropped; a start in cycle 12 is accepted.
        run_op("busy_start",   1'b0, 384'd50, 384'd60, 384'd97, 384'd13, 3, 11);
        run_op("b2b_accept",   1'b1, 384'd5, 384'd9, 384'd97, 384'd93, -1, -1);

        // Reset during WAIT2 (cycle 7)
        start    = 1'b1;
        subtract = 1'b0;
        in_a     = 384'd40;
        in_b     = 384'd41;
        in_m     = 384'd97;
        dcnt     = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = (c == 7);
            if (done) dcnt++;
            if (c >= 8 && c <= 11) chk($sformatf("midrst.busy%0d", c), busy, 1);
            if (c == 8) chk("midrst.result0", result, 0);
        end
        chk("midrst.no_done", dcnt, 0);
        chk("midrst.result_held", result, 0);
        run_op("after_rst", 1'b0, 384'd40, 384'd41, 384'd97, 384'd81, -1, -1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            if (i % 2 == 0) rm = {352'b0, 32'($urandom)} | 384'd1;
            else            rm = rnd384() | 384'd1;
            if (rm == 384'd1) rm = 384'd3;
            if (i % 8 == 5)   rm = ones;
            ra = rnd384() % rm;
            rb = rnd384() % rm;
            run_op($sformatf("rand%0d", i), rs, ra, rb, rm, ref_model(rs, ra, rb, rm), -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_addsub_ctrl.md
# mod_addsub_ctrl

Controller that computes 384-bit modular addition or subtraction, (A ± B) mod M, by running two passes through the shared 384-bit pipelined adder (128-bit slice, start/done handshake, 4-cycle latency). It sits between the ECDSA point-arithmetic sequencer and the adder. It latches operands, drives the adder's start/Cin/A/B, applies the conditional reduction, and returns a registered result. Both passes always execute, so latency is independent of the operand values.

## Interface
- No parameters; widths fixed (N = 384).
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- subtract  in  1  0: A+B mod M, 1: A−B mod M; latched with start
- in_a  in  384  operand A; latched with start
- in_b  in  384  operand B; latched with start
- in_m  in  384  modulus M; latched with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  384  registered result; held until next accepted start
- add_start  out  1  one-cycle start pulse to adder
- add_cin  out  1  adder carry-in; stable while add_start high
- add_a  out  384  adder operand A
- add_b  out  384  adder operand B
- add_c  in  385  adder sum, bit 384 = carry-out
- add_done  in  1  adder completion pulse

## Operation
- States: FLUSH, IDLE, LOAD1, WAIT1, LOAD2, WAIT2, DONE.
- Reset enters FLUSH. All outputs reset to 0: busy, done, result, add_start, add_cin, add_a, add_b. Exception: busy reads 1 while in FLUSH.
- FLUSH lasts 4 cycles (2-bit counter), then goes to IDLE. The adder has no reset, so this drains any pass that was in flight when rst hit. add_done is ignored in FLUSH, IDLE and DONE.
- IDLE: on start, latch subtract/A/B/M and go to LOAD1. start in any other state is ignored, with no queueing.
- LOAD1 drives add_start=1 for one cycle, then goes to WAIT1.
  - Add: add_a=A, add_b=B, add_cin=0.
  - Sub: add_a=A, add_b=~B, add_cin=1.
- WAIT1: on add_done, capture S1=add_c[383:0] and k1=add_c[384], then go to LOAD2.
- LOAD2 drives add_start=1, then goes to WAIT2.
  - Add: add_a=S1, add_b=~M, add_cin=1 (computes S1−M).
  - Sub: add_a=S1, add_b=M, add_cin=0 (computes S1+M).
- WAIT2: on add_done, capture S2=add_c[383:0] and k2=add_c[384], write result, then go to DONE.
  - Add: result = (k1 | k2) ? S2 : S1.
  - Sub: result = k1 ? S1 : S2, since k1=0 means a borrow occurred.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE.
- Operand precondition: A, B < M and M odd > 1. Out-of-range operands still give the formula above; no error flag.
- add_a/add_b/add_cin hold their values after the add_start cycle (the adder samples only on start).
- rst in any state wins: the next state is FLUSH, done is not pulsed, and result clears to 0.

## Timing
- Adder contract: add_start high in cycle t gives add_done high in cycle t+4, with add_c valid only in t+4.
- start accepted in cycle 0: LOAD1 = cycle 1, WAIT1 = cycles 2–5, LOAD2 = cycle 6, WAIT2 = cycles 7–10, DONE = cycle 11, IDLE = cycle 12.
- done high in cycle 11. This latency is fixed for both add and sub and for every operand value.
- busy rises in cycle 1 (the cycle after start) and falls in cycle 12.
- Back-to-back throughput: one operation per 12 cycles.
- rst high in cycle r: FLUSH during r+1..r+4, IDLE in r+5. start is accepted no earlier than r+5.

## Test plan
- Add, no reduction: M=97, A=10, B=20 -> done in cycle 11, result=30.
- Add, reduction: M=97, A=50, B=60 -> result=13.
- Sub, both cases:
  - M=97, A=20, B=10 -> result=10.
  - M=97, A=10, B=20 -> result=87.
  - Each done exactly 11 cycles after start.
- Carry-out case: M=2^384−1, A=B=2^384−2 -> result=2^384−3.
- Start while busy: second start in cycles 3 and 11 -> ignored, one done pulse only, result from the first request; a start in cycle 12 is accepted.
- Reset mid-op: rst in cycle 7 (during WAIT2) -> no done pulse, result=0, busy=1 for 4 flush cycles. A stale add_done is ignored. A new start after flush returns the correct result.
